// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl: adds two WIDTH-bit operands through one shared external
// CLA_16 slice, one 16-bit chunk per cycle, LSB chunk first. The carry moves
// from one chunk to the next through an internal register.
// Optional feature macro: CLA_SEQ_ADD_SUB_EN adds subtract mode (A - B via
// stored ~B and an initial carry of 1). When it is undefined, sub_in is ignored.
module cla_seq_add_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_valid_in,
  output logic             start_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             busy_out,
  output logic [15:0]      slice_a_out,
  output logic [15:0]      slice_b_out,
  output logic             slice_c_out,
  input  logic [15:0]      slice_s_in,
  input  logic             slice_c_in
);

  localparam int NCHUNK = WIDTH / 16;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;   // effective B: already inverted when subtracting
  logic             carry;   // carry into the current chunk
  logic [15:0]      a_chunk;
  logic [15:0]      b_chunk;
  logic             b_eff_in;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Effective operand B and initial carry captured at accept.
`ifdef CLA_SEQ_ADD_SUB_EN
  assign b_load = sub_in ? ~b_in : b_in;
  assign c_load = sub_in ? 1'b1 : c_in;
`else
  logic unused_sub;
  assign unused_sub = sub_in;
  assign b_load     = b_in;
  assign c_load     = c_in;
`endif

  // Status flags decode directly from the state register.
  assign start_ready_out = (state == S_IDLE);
  assign busy_out        = (state == S_RUN);
  assign res_valid_out   = (state == S_DONE);

  // Select the current 16-bit chunk of each stored operand.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        a_chunk = a_reg[16*i +: 16];
        b_chunk = b_reg[16*i +: 16];
      end
    end
  end

  // Drive the slice only in RUN; hold it at zero otherwise to avoid toggling.
  assign slice_a_out = busy_out ? a_chunk : 16'h0000;
  assign slice_b_out = busy_out ? b_chunk : 16'h0000;
  assign slice_c_out = busy_out ? carry   : 1'b0;

  // Sign bit of B as it enters the adder, used for the overflow check.
  assign b_eff_in = b_reg[WIDTH-1];

  // Sequencer: accept, walk the chunks, then hold the result until taken.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      s_out   <= '0;
      c_out   <= 1'b0;
      ovf_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid_in) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            a_reg <= a_in;
            b_reg <= b_load;
            carry <= c_load;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) s_out[16*i +: 16] <= slice_s_in;
          end
          carry <= slice_c_in;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            c_out   <= slice_c_in;
            ovf_out <= (a_reg[WIDTH-1] == b_eff_in) &&
                       (slice_s_in[15] != a_reg[WIDTH-1]);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Testbench for cla_seq_add_ctrl (WIDTH=64). A behavioural CLA_16 drives the
// slice inputs, and a reference model computes each result with plain
// wide arithmetic. Follows CLA_SEQ_ADD_SUB_EN the same way the design does.
module tb_cla_seq_add_ctrl;

  localparam int W  = 64;
  localparam int NC = W / 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_valid_in;
  logic          start_ready_out;
  logic [W-1:0]  a_in, b_in;
  logic          c_in, sub_in;
  logic          res_valid_out;
  logic          res_ready_in;
  logic [W-1:0]  s_out;
  logic          c_out, ovf_out, busy_out;
  logic [15:0]   slice_a_out, slice_b_out, slice_s_in;
  logic          slice_c_out, slice_c_in;

  int vectors = 0;
  int miscompares = 0;

  cla_seq_add_ctrl #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_valid_in(start_valid_in), .start_ready_out(start_ready_out),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub_in(sub_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .s_out(s_out), .c_out(c_out), .ovf_out(ovf_out), .busy_out(busy_out),
    .slice_a_out(slice_a_out), .slice_b_out(slice_b_out), .slice_c_out(slice_c_out),
    .slice_s_in(slice_s_in), .slice_c_in(slice_c_in)
  );

  // Behavioural CLA_16 slice.
  assign {slice_c_in, slice_s_in} = {1'b0, slice_a_out} + {1'b0, slice_b_out} + {16'h0000, slice_c_out};

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Effective B and initial carry as the operation defines them.
  function automatic void eff_ops(input logic [W-1:0] b, input logic c, input logic sub,
                                  output logic [W-1:0] beff, output logic ceff);
`ifdef CLA_SEQ_ADD_SUB_EN
    beff = sub ? ~b : b;
    ceff = sub ? 1'b1 : c;
`else
    beff = b;
    ceff = c;
`endif
  endfunction

  // Full-width reference result.
  function automatic void model(input logic [W-1:0] a, b, input logic c, sub,
                                output logic [W-1:0] s, output logic co, ov);
    logic [W-1:0] beff;
    logic         ceff;
    logic [W:0]   t;
    eff_ops(b, c, sub, beff, ceff);
    t  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, ceff};
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Carry entering chunk k: carry out of the low 16*k bits of A + Beff + cin.
  function automatic logic chunk_carry(input logic [W-1:0] a, beff, input logic ceff, input int k);
    logic [W:0] mask, t;
    if (k == 0) return ceff;
    mask = ({{W{1'b0}}, 1'b1} << (16 * k)) - 1;
    t    = ({1'b0, a} & mask) + ({1'b0, beff} & mask) + {{W{1'b0}}, ceff};
    return t[16 * k];
  endfunction

  // Present a request, wait for the result, and check slice drive plus latency.
  task automatic launch(input string tag, input logic [W-1:0] a, b, input logic c, sub);
    logic [W-1:0] beff;
    logic         ceff;
    int           cyc;
    eff_ops(b, c, sub, beff, ceff);
    cyc = 0;
    while (!start_ready_out && cyc < 20) begin tick(); cyc++; end
    if (!start_ready_out) check({tag, "_ready_timeout"}, 64'(start_ready_out), 64'd1);
    a_in = a; b_in = b; c_in = c; sub_in = sub; start_valid_in = 1'b1;
    tick();
    start_valid_in = 1'b0;
    a_in = $urandom; b_in = $urandom; c_in = 1'b0; sub_in = 1'b0;
    cyc = 0;
    while (!res_valid_out && cyc < 20) begin
      if (cyc < NC) begin
        check({tag, "_slice_a"}, 64'(slice_a_out), 64'(a[16*cyc +: 16]));
        check({tag, "_slice_b"}, 64'(slice_b_out), 64'(beff[16*cyc +: 16]));
        check({tag, "_slice_c"}, 64'(slice_c_out), 64'(chunk_carry(a, beff, ceff, cyc)));
      end
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(NC));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, b, input logic c, sub);
    logic [W-1:0] es;
    logic         ec, eo;
    model(a, b, c, sub, es, ec, eo);
    check({tag, "_valid"}, 64'(res_valid_out), 64'd1);
    check({tag, "_s"}, s_out, es);
    check({tag, "_c"}, 64'(c_out), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf_out), 64'(eo));
  endtask

  task automatic release_result(input string tag);
    res_ready_in = 1'b1;
    tick();
    res_ready_in = 1'b0;
    check({tag, "_valid_drop"}, 64'(res_valid_out), 64'd0);
    check({tag, "_ready_back"}, 64'(start_ready_out), 64'd1);
    check({tag, "_not_busy"}, 64'(busy_out), 64'd0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, b, input logic c, sub);
    launch(tag, a, b, c, sub);
    check_result(tag, a, b, c, sub);
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W-1:0] held_s;
    int           wait_n;

    rst_in = 1'b1; start_valid_in = 1'b0; res_ready_in = 1'b0;
    a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
    #12;
    check("rst_ready", 64'(start_ready_out), 64'd1);
    check("rst_valid", 64'(res_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_s", s_out, 64'd0);
    check("rst_c", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf_out), 64'd0);
    check("rst_slice", {15'd0, slice_c_out, slice_b_out, slice_a_out}, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();

    // Directed corner cases.
    op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    op("chunk_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    op("cin", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0);

    // Backpressure: result held, new requests ignored.
    launch("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    check_result("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    held_s = s_out;
    for (int i = 0; i < 10; i++) begin
      start_valid_in = (i % 3 == 1);
      a_in = 64'h5; b_in = 64'h6;
      tick();
      check("bp_hold_valid", 64'(res_valid_out), 64'd1);
      check("bp_hold_ready", 64'(start_ready_out), 64'd0);
      check("bp_hold_s", s_out, held_s);
    end
    start_valid_in = 1'b0;
    check_result("bp_end", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    release_result("bp");

    // Reset in chunk 2 of RUN discards everything.
    a_in = 64'hAAAA_AAAA_AAAA_AAAA; b_in = 64'h5555_5555_5555_5555; c_in = 1'b1;
    start_valid_in = 1'b1;
    tick();
    start_valid_in = 1'b0;
    tick();
    tick();
    check("mid_busy_before", 64'(busy_out), 64'd1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", 64'(res_valid_out), 64'd0);
    check("mid_rst_busy", 64'(busy_out), 64'd0);
    check("mid_rst_s", s_out, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();
    check("mid_rst_ready", 64'(start_ready_out), 64'd1);
    op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0);

    // Subtract request (honoured only when the feature is built in).
    op("sub", 64'd5, 64'd7, 1'b0, 1'b1);

    // Randomised operations with random consumer delay.
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 6 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      launch("rnd", ra, rb, rc, rs);
      wait_n = $urandom_range(0, 3);
      for (int d = 0; d < wait_n; d++) tick();
      check_result("rnd", ra, rb, rc, rs);
      release_result("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
